// File: rtl/async_req_arbiter.sv
// Synchronizes asynchronous request lines, latches each rising edge as a pending
// event, and grants pending events round-robin to one shared resource until done.
module async_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int STAGES  = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] async_req_i,
    input  logic               done_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic [NUM_REQ-1:0] pending_o,
    output logic [NUM_REQ-1:0] drop_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    (* ASYNC_REG = "TRUE" *) logic [NUM_REQ-1:0] sync_q [STAGES];
    logic [NUM_REQ-1:0] sync_d [STAGES];
    logic [NUM_REQ-1:0] prev_q, prev_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] drop_q, drop_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] sync, rise, clr;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum -= NUM_REQ;
        return IDX_W'(sum);
    endfunction

    always_comb begin
        sync_d[0] = async_req_i;
        for (int s = 1; s < STAGES; s++) sync_d[s] = sync_q[s-1];
    end

    assign sync   = sync_q[STAGES-1];
    assign prev_d = sync;
    assign rise   = sync & ~prev_q;

    // Scan starts just after the last winner, so the previous owner is checked last.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!win_found && pending_q[wrap_idx(last_idx_q, off)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(last_idx_q, off);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        clr        = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d      = NUM_REQ'(1) << win_idx;
                    gnt_idx_d  = win_idx;
                    last_idx_d = win_idx;
                    clr        = NUM_REQ'(1) << win_idx;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done_i) begin
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new edge on the bit being granted survives; one on an untouched pending bit is merged.
        drop_d    = drop_q | (rise & pending_q & ~clr);
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the synchronizer chain is cleared too, so a line already high at release reads as a fresh event.
            for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_idx_q <= IDX_W'(NUM_REQ - 1);
            state_q    <= ST_IDLE;
        end else begin
            for (int s = 0; s < STAGES; s++) sync_q[s] <= sync_d[s];
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            state_q    <= state_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == ST_BUSY);
    assign gnt_idx_o   = gnt_idx_q;
    assign pending_o   = pending_q;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Bench for async_req_arbiter: fixed vector table, directed corner sequences,
// and randomized traffic compared every cycle against an event-level model.
module tb_async_req_arbiter;

    localparam int NR     = 4;
    localparam int STAGES = 2;
    localparam int IW     = 2;

    typedef struct packed {
        logic          rst;
        logic [NR-1:0] req;
        logic          done;
        logic [NR-1:0] gnt;
        logic          valid;
        logic [IW-1:0] idx;
        logic [NR-1:0] pend;
        logic [NR-1:0] drop;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          done;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt_o, pending_o, drop_o;
    logic          gnt_valid_o;
    logic [IW-1:0] gnt_idx_o;

    int n_cmp = 0;
    int n_err = 0;

    vec_t          vecs [9];
    logic [NR-1:0] step_pend [4];

    // Reference model state: a queue of past input samples stands in for the synchronizer delay.
    logic [NR-1:0] m_hist [$];
    logic [NR-1:0] m_prev, m_pend, m_drop;
    bit            m_busy;
    int            m_owner, m_last;

    async_req_arbiter #(.NUM_REQ(NR), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .async_req_i(req),
        .done_i     (done),
        .gnt_o      (gnt_o),
        .gnt_valid_o(gnt_valid_o),
        .gnt_idx_o  (gnt_idx_o),
        .pending_o  (pending_o),
        .drop_o     (drop_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [NR-1:0] sync, rise, clr;
        bit            found;
        int            w;
        if (rst) begin
            m_hist.delete();
            repeat (STAGES) m_hist.push_back('0);
            m_prev  = '0;
            m_pend  = '0;
            m_drop  = '0;
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = NR - 1;
        end else begin
            sync  = m_hist[$];
            rise  = sync & ~m_prev;
            clr   = '0;
            found = 1'b0;
            w     = 0;
            if (!m_busy) begin
                if (m_pend != '0) begin
                    for (int k = 1; k <= NR; k++) begin
                        if (!found && m_pend[(m_last + k) % NR]) begin
                            found = 1'b1;
                            w     = (m_last + k) % NR;
                        end
                    end
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_last  = w;
                    clr[w]  = 1'b1;
                end
            end else if (done) begin
                m_busy = 1'b0;
            end
            m_drop = m_drop | (rise & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | rise;
            m_prev = sync;
            m_hist.push_front(req);
            void'(m_hist.pop_back());
        end
    endtask

    task automatic check_model();
        logic [NR-1:0] eg;
        eg = m_busy ? (NR'(1) << m_owner) : '0;
        check("mdl_gnt",   gnt_o,       eg);
        check("mdl_valid", gnt_valid_o, m_busy);
        check("mdl_idx",   gnt_idx_o,   m_busy ? m_owner : 0);
        check("mdl_pend",  pending_o,   m_pend);
        check("mdl_drop",  drop_o,      m_drop);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int idx);
        int n;
        n = 0;
        while (!gnt_valid_o && n < 30) begin
            tick();
            n++;
        end
        check("grant_seen", gnt_valid_o, 1'b1);
        idx = int'(gnt_idx_o);
    endtask

    task automatic finish_grant();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;

        //          rst   req      done  gnt      valid idx    pend     drop
        vecs[0] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[1] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[2] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[3] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[4] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0100, 4'b0000};
        vecs[5] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 4'b0000};
        vecs[6] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 4'b0000};
        vecs[7] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000};
        vecs[8] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000};
        step_pend[0] = 4'b1110;
        step_pend[1] = 4'b1100;
        step_pend[2] = 4'b1000;
        step_pend[3] = 4'b0000;

        rst  = 1'b1;
        req  = '0;
        done = 1'b0;

        // Single request on line 2 with fixed expectations.
        for (int i = 0; i < 9; i++) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            done = vecs[i].done;
            tick();
            check($sformatf("vec%0d_gnt", i),   gnt_o,       vecs[i].gnt);
            check($sformatf("vec%0d_valid", i), gnt_valid_o, vecs[i].valid);
            check($sformatf("vec%0d_idx", i),   gnt_idx_o,   vecs[i].idx);
            check($sformatf("vec%0d_pend", i),  pending_o,   vecs[i].pend);
            check($sformatf("vec%0d_drop", i),  drop_o,      vecs[i].drop);
        end

        // All four lines rise together: order 0,1,2,3 with one idle cycle between grants.
        do_reset();
        req = 4'b1111;
        repeat (3) tick();
        req = '0;
        check("all_pend", pending_o, 4'b1111);
        for (int g = 0; g < 4; g++) begin
            wait_grant(w);
            check($sformatf("all_order%0d", g), w, g);
            check($sformatf("all_pend%0d", g), pending_o, step_pend[g]);
            tick();
            finish_grant();
            check($sformatf("all_gap%0d", g), gnt_valid_o, 1'b0);
            tick();
            check($sformatf("all_next%0d", g), gnt_valid_o, (g < 3) ? 1'b1 : 1'b0);
        end

        // Fairness: 0 re-requests during its grant, 3 must still be served before 0 again.
        do_reset();
        req = 4'b1001;
        wait_grant(w);
        check("fair_first", w, 0);
        req = 4'b1000;
        repeat (3) tick();
        req = 4'b1001;
        repeat (3) tick();
        check("fair_pend", pending_o, 4'b1001);
        finish_grant();
        wait_grant(w);
        check("fair_second", w, 3);
        finish_grant();
        wait_grant(w);
        check("fair_third", w, 0);
        finish_grant();
        req = '0;

        // Drop: line 1 rises twice while 0 is held.
        do_reset();
        req = 4'b0001;
        wait_grant(w);
        req = 4'b0011;
        repeat (3) tick();
        req = 4'b0001;
        repeat (3) tick();
        req = 4'b0011;
        repeat (3) tick();
        check("drop_set", drop_o, 4'b0010);
        check("drop_pend", pending_o, 4'b0010);
        finish_grant();
        wait_grant(w);
        check("drop_gnt", w, 1);
        finish_grant();
        cnt = 0;
        repeat (6) begin
            tick();
            if (gnt_valid_o) cnt++;
        end
        check("drop_once", cnt, 0);
        check("drop_sticky", drop_o, 4'b0010);
        do_reset();
        check("drop_clr", drop_o, 4'b0000);

        // Set/clear collision: line 1 rises on the cycle it is granted.
        req = 4'b0001;
        wait_grant(w);
        req = 4'b0011;
        repeat (3) tick();
        req = 4'b0001;
        repeat (3) tick();
        req = 4'b0011;
        tick();
        finish_grant();
        tick();
        check("col_gnt", gnt_o, 4'b0010);
        check("col_pend", pending_o, 4'b0010);
        check("col_drop", drop_o, 4'b0000);
        finish_grant();
        wait_grant(w);
        check("col_regrant", w, 1);
        finish_grant();

        // Reset while busy, line 3 held high through reset.
        do_reset();
        req = 4'b0001;
        wait_grant(w);
        req = 4'b1011;
        repeat (3) tick();
        check("rst_pend", pending_o, 4'b1010);
        rst = 1'b1;
        req = 4'b1000;
        tick();
        check("rst_gnt", gnt_o, 4'b0000);
        check("rst_valid", gnt_valid_o, 1'b0);
        check("rst_pend0", pending_o, 4'b0000);
        tick();
        rst = 1'b0;
        cnt = 0;
        while (!gnt_valid_o && cnt < 20) begin
            tick();
            cnt++;
        end
        check("rst_latency", cnt, STAGES + 2);
        check("rst_gnt3", gnt_o, 4'b1000);
        finish_grant();

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = NR'($urandom);
            done = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/async_req_arbiter.md
Name: async_req_arbiter

Overview:
- Accepts NUM_REQ asynchronous request lines, one per requester.
- Each line passes through an internal multi-flop synchronizer chain, then a rising-edge detector. Each detected edge latches a pending event.
- Pending events are granted round-robin, one at a time, to a single shared resource. Each grant is held until the resource signals completion.
- Sits between asynchronous event sources (external pins, foreign-domain strobes) and a shared single-owner engine in the clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- STAGES, 2, synchronizer flops per request line (>=2). Every flop carries ASYNC_REG.
- IDX_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high; clears all state, including the synchronizer flops.
- async_req_i  input  NUM_REQ  asynchronous requests; a rising edge is an event.
- done_i  input  1  resource finished with the current grant; sampled only in BUSY.
- gnt_o  output  NUM_REQ  one-hot grant, registered, held through BUSY.
- gnt_valid_o  output  1  high whenever gnt_o is non-zero (i.e. in BUSY).
- gnt_idx_o  output  IDX_W  binary index of the granted requester; 0 when idle.
- pending_o  output  NUM_REQ  latched, not-yet-granted events.
- drop_o  output  NUM_REQ  sticky; set when an edge arrives while that bit is already pending. Cleared only by rst.

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Sync chains and the previous-value registers are 0.
  - The round-robin pointer last_idx = NUM_REQ-1, so requester 0 has top priority first.
- Synchronizer:
  - Per bit: shift register of STAGES flops; sync = last stage.
  - prev register holds last-cycle sync.
  - rise = sync & ~prev.
- Latency:
  - An input high before edge 1 sets sync at edge STAGES.
  - pending is set at edge STAGES+1.
  - If IDLE, gnt_o is asserted at edge STAGES+2.
- An input already high when rst deasserts is treated as an event, because the chain was reset to 0.
- Pulses shorter than one clk period may be missed. This is a documented limitation; requesters must hold their request for at least 2 clk periods.
- Pending update each cycle:
  - pending[i] is set on rise[i].
  - pending[i] is cleared when i wins a grant.
  - If both happen in the same cycle, set wins and the new event is kept.
  - If rise[i] occurs while pending[i] is already 1 and not being cleared, drop_o[i] is set and the event is merged.
- FSM states: IDLE, BUSY.
  - IDLE with pending==0: stay in IDLE.
  - IDLE with pending!=0: winner = first set bit scanning last_idx+1, last_idx+2, ... modulo NUM_REQ. At the next edge:
    - gnt_o = onehot(winner), gnt_idx_o = winner, gnt_valid_o = 1;
    - pending[winner] cleared; last_idx = winner; state becomes BUSY.
  - BUSY with done_i=0: hold all grant outputs unchanged. There is no timeout.
  - BUSY with done_i=1: at the next edge, gnt_o = 0, gnt_valid_o = 0, gnt_idx_o = 0, state becomes IDLE.
- done_i high on the first BUSY cycle is legal and gives a 1-cycle grant.
- done_i in IDLE is ignored.
- At least one IDLE cycle separates consecutive grants, so back-to-back grants are 2 cycles apart minimum.
- New events during BUSY, including from the current owner, only set pending. They are arbitrated after return to IDLE.
- rst asserted mid-grant:
  - outputs drop to 0 at that edge;
  - all pending events and drop flags are discarded.

Test Plan:
- Reset, then a single pulse on async_req_i[2] held 3 cycles, STAGES=2:
  - pending_o=4'b0100 at edge 3 after the rise;
  - gnt_o=4'b0100 and gnt_idx_o=2 at edge 4;
  - done_i pulsed for 1 cycle -> gnt_o=0 on the next edge.
- All 4 requests rise on the same cycle, done_i returned 2 cycles after each grant:
  - grant order 0,1,2,3;
  - gnt_valid_o is low for exactly 1 cycle between grants;
  - pending_o steps 1111 -> 1110 -> 1100 -> 1000 -> 0000.
- Fairness: requester 0 re-requests during every grant while requester 3 requests once -> order 0,1?,...,3 is served before 0's second grant (requester 0 never served twice before 3).
- Drop:
  - req1 rises twice while req0 is held in BUSY -> drop_o[1]=1, only one grant to 1;
  - drop_o stays 1 until rst.
- Set/clear collision: req1 rises on the exact cycle 1 is granted -> pending_o[1]=1 after the grant edge, and 1 is granted again after done.
- Reset mid-operation:
  - rst asserted while BUSY with pending=1010 -> all outputs 0 the next edge;
  - with async_req_i[3] held high through reset -> a grant to 3 follows STAGES+2 edges after rst release.
